// File: rtl/io_handshake_sequencer_pkg.sv
// Shared I/O definitions: user-I/O opcodes, sequencer state encoding and
// the sign-magnitude helper used by the display path.
package io_pkg;

    localparam logic [5:0] OP_IN  = 6'b011101;
    localparam logic [5:0] OP_OUT = 6'b100000;
    localparam logic [5:0] OP_HLT = 6'b011100;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_IN_WAIT_PRESS  = 3'd1,
        ST_IN_WAIT_REL    = 3'd2,
        ST_OUT_WAIT_PRESS = 3'd3,
        ST_OUT_WAIT_REL   = 3'd4,
        ST_HALT           = 3'd5
    } io_state_e;

    // Two's-complement to magnitude; 0x80000000 maps onto itself, which is
    // exactly the unsigned magnitude 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/io_handshake_sequencer_debouncer.sv
// Pushbutton conditioning: two-flop synchroniser followed by a stability
// counter. The debounced level only changes after the synchronised input
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any
// bounce back to the current level restarts the count.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic raw_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Count consecutive disagreeing cycles; flip the level and emit a
    // one-cycle edge pulse when the count completes.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d   = sync2_q;
                press_d   = ~sync2_q;
                release_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state; reset to the released (high) level.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            level_q   <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_n_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/io_handshake_sequencer.sv
// User-I/O sequencer: stalls the CPU on IN (and optionally OUT) until the
// operator presses and releases CONFIRM, drives the sign-magnitude display
// registers on OUT and freezes the CPU on HLT.
module io_handshake_sequencer
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit OUT_ACK         = 1'b0,
    parameter int SW_WIDTH        = 18
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [5:0]          operation,
    input  logic                op_valid,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                confirm_n,
    input  logic [31:0]         out_data,
    output logic                stall,
    output logic [31:0]         in_data,
    output logic                in_valid,
    output logic [31:0]         display_bin,
    output logic                neg_led,
    output logic                in_led,
    output logic                out_led,
    output logic                halted
);

    io_state_e   state_q;
    logic [31:0] in_data_q;
    logic [31:0] disp_q;
    logic        neg_q, in_led_q, out_led_q, halted_q;
    logic        btn_level, btn_press, btn_release;
    logic        stall_raw, complete_in;
    logic [31:0] sw_ext;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_confirm (
        .clock_i  (clock),
        .reset_n_i(reset_n),
        .raw_n_i  (confirm_n),
        .level_o  (btn_level),
        .press_o  (btn_press),
        .release_o(btn_release)
    );

    assign sw_ext      = 32'(switches);
    assign complete_in = reset_n && (state_q == ST_IN_WAIT_REL) && btn_release;

    // Stall is combinational so the CPU holds in the very cycle an op is
    // accepted and advances in the very cycle the release is seen.
    always_comb begin
        stall_raw = 1'b1;
        case (state_q)
            ST_IDLE: stall_raw = op_valid && ((operation == OP_IN) ||
                                              (operation == OP_HLT) ||
                                              (OUT_ACK && (operation == OP_OUT)));
            ST_IN_WAIT_REL,
            ST_OUT_WAIT_REL: stall_raw = ~btn_release;
            default: stall_raw = 1'b1;
        endcase
    end

    // Sequencer FSM together with the display, IN result and LED registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            in_data_q <= '0;
            disp_q    <= '0;
            neg_q     <= 1'b0;
            in_led_q  <= 1'b0;
            out_led_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (operation)
                            OP_IN: begin
                                state_q  <= ST_IN_WAIT_PRESS;
                                in_led_q <= 1'b1;
                            end
                            OP_OUT: begin
                                neg_q  <= out_data[31];
                                disp_q <= magnitude(out_data);
                                if (OUT_ACK) begin
                                    state_q   <= ST_OUT_WAIT_PRESS;
                                    out_led_q <= 1'b1;
                                end
                            end
                            OP_HLT: begin
                                state_q   <= ST_HALT;
                                halted_q  <= 1'b1;
                                in_led_q  <= 1'b1;
                                out_led_q <= 1'b1;
                                neg_q     <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_IN_WAIT_PRESS: if (btn_press) state_q <= ST_IN_WAIT_REL;
                ST_IN_WAIT_REL: begin
                    if (btn_release) begin
                        state_q   <= ST_IDLE;
                        in_led_q  <= 1'b0;
                        in_data_q <= sw_ext;
                    end
                end
                ST_OUT_WAIT_PRESS: if (btn_press) state_q <= ST_OUT_WAIT_REL;
                ST_OUT_WAIT_REL: begin
                    if (btn_release) begin
                        state_q   <= ST_IDLE;
                        out_led_q <= 1'b0;
                    end
                end
                ST_HALT: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A release pulse always coincides with the debounced level reading released.
    always @(posedge clock) begin
        if (reset_n && btn_release) assert (btn_level);
    end

    assign stall       = reset_n && stall_raw;
    assign in_valid    = complete_in;
    assign in_data     = complete_in ? sw_ext : in_data_q;
    assign display_bin = disp_q;
    assign neg_led     = neg_q;
    assign in_led      = in_led_q;
    assign out_led     = out_led_q;
    assign halted      = halted_q;

endmodule
